// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port, holds the IR, squashes on redirect.
// Optional memory-wait counter is built only when FETCH_WAIT_CNT_EN is defined.
module fetch_unit #(
  parameter int unsigned         PC_W     = 8,
  parameter int unsigned         INSTR_W  = 8,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [PC_W-1:0]    ir_pc,
  output logic [4:0]         opcode,
  output logic [2:0]         operand,
  output logic [15:0]        fetch_wait_cnt
);

  // Memory handshake: a request is outstanding while imem_req=1 and imem_addr is held
  // stable until the cycle where imem_ack=1; that cycle completes it and imem_rdata is sampled.
  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic               ir_valid_q, ir_valid_d;
  logic [INSTR_W-1:0] ir_instr_q, ir_instr_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_valid_d = ir_valid_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;

    // Remember the address of the request in flight so a squash can keep driving it.
    if (state_q == ST_FETCH) req_addr_d = pc_q;

    if (redirect_en) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      if (state_q == ST_HOLD || imem_ack) state_d = ST_FETCH;
      else                                state_d = ST_SQUASH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            ir_instr_d = imem_rdata;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + PC_W'(1);
            ir_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ir_valid_q && !stall) begin
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
          end
        end
        ST_SQUASH: begin
          if (imem_ack) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_valid_q <= ir_valid_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  assign imem_req  = (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_SQUASH) ? req_addr_q : pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir_instr  = ir_instr_q;
  assign ir_pc     = ir_pc_q;
  assign opcode    = ir_instr_q[INSTR_W-1 -: 5];
  assign operand   = ir_instr_q[2:0];

`ifdef FETCH_WAIT_CNT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Counts every cycle a request waits on memory, squash cycles included; sticks at all-ones.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (imem_req && !imem_ack && (wait_cnt_q != 16'hFFFF)) wait_cnt_d = wait_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign fetch_wait_cnt = wait_cnt_q;
`else
  assign fetch_wait_cnt = '0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the accumulator softcore, sitting directly upstream of the `control` decoder. It owns the program counter and issues requests to instruction memory using a req/ack handshake. It latches each returned 8-bit instruction into an instruction register (IR) and presents the 5-bit opcode and 3-bit operand field to decode and execute. It also applies PC redirects from branches and `jmpadr`, and squashes any fetch still in flight when a redirect arrives.

## Interface
- `PC_W`, 8: program counter and instruction address width.
- `INSTR_W`, 8: instruction width; opcode = `[INSTR_W-1:INSTR_W-5]`, operand = `[2:0]`.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  PC_W  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  INSTR_W  instruction word; sampled only when `imem_req & imem_ack`.
- `redirect_en`  in  1  single-cycle pulse: take branch or jump.
- `redirect_pc`  in  PC_W  redirect target.
- `stall`  in  1  downstream is not ready to consume the IR.
- `ir_valid`  out  1  IR holds an unconsumed instruction.
- `ir_instr`  out  INSTR_W  latched instruction.
- `ir_pc`  out  PC_W  address of `ir_instr` (feeds `cpypc` and PC-relative branches).
- `opcode`  out  5  `ir_instr[INSTR_W-1:INSTR_W-5]`, wired straight to `control`.
- `operand`  out  3  `ir_instr[2:0]`: register index x0–x6, or the immediate.
- `fetch_wait_cnt`  out  16  memory-wait counter (see Configuration).

## Operation
- States: FETCH, HOLD, SQUASH. Held in registers `pc`, `state`, `ir_instr`, `ir_pc`, `ir_valid`.
- `imem_req` = 1 in FETCH and SQUASH, 0 in HOLD. `imem_addr` = `pc`.
- A consume happens when `ir_valid & ~stall` is true at a clock edge.
- FETCH:
  - On `imem_ack`: `ir_instr`←`imem_rdata`, `ir_pc`←`pc`, `pc`←`pc+1` (mod 2^PC_W), `ir_valid`←1, go to HOLD.
  - Without ack: remain in FETCH.
- HOLD:
  - On consume: `ir_valid`←0, go to FETCH.
  - On stall: IR and `pc` stay frozen.
- Redirect (`redirect_en`=1) has highest priority and always clears `ir_valid`. `pc`←`redirect_pc`, then:
  - in HOLD, go to FETCH;
  - in FETCH or SQUASH with `imem_ack`=1, the data is discarded and the next state is FETCH;
  - in FETCH or SQUASH with `imem_ack`=0, go to SQUASH.
- SQUASH:
  - The outstanding request is held to completion. `imem_addr` stays equal to the original address, held in a separate `req_addr` register.
  - On ack, the data is discarded and the state goes to FETCH at `pc` (the redirect target).
  - A later redirect during SQUASH overwrites the target.
- Because `imem_addr` must come from `req_addr` in SQUASH, `req_addr` captures `pc` on every FETCH cycle.
- Reset values: state=FETCH, `pc`=RESET_PC, `req_addr`=RESET_PC, `ir_valid`=0, `ir_instr`=0, `ir_pc`=0, `fetch_wait_cnt`=0. `imem_req` is 1 in the first cycle after reset. `rst` overrides a redirect or ack in the same cycle.

## Timing
- With zero-wait memory (ack in the request cycle), fetch to `ir_valid` is 1 cycle and throughput is 1 instruction per 2 cycles.
- With N wait cycles, `ir_valid` rises N+1 cycles after FETCH is entered.
- Redirect takes effect on the next edge. The first instruction from the target reaches the IR at the earliest 2 cycles after the redirect pulse, or later if a squash is in progress.
- `opcode` and `operand` are purely combinational slices of `ir_instr` and are valid whenever `ir_valid`=1.

## Configuration
- `FETCH_WAIT_CNT_EN` defined:
  - `fetch_wait_cnt` increments on each cycle with `imem_req & ~imem_ack`, including SQUASH cycles.
  - It saturates at 16'hFFFF and clears only on `rst`.
- Undefined: `fetch_wait_cnt` is tied to 0 and no counter flops are built.

## Test plan
- Reset, memory acks every cycle, `stall`=0, memory holds 8'h11, 8'h22, 8'h33 at addresses 0–2 -> `ir_valid` high on cycles 1, 3, 5 with `ir_pc`=0, 1, 2; `opcode`=5'b00010 for 8'h11.
- Hold `stall`=1 for 4 cycles with an IR valid -> `ir_instr`, `ir_pc`, `pc` unchanged and `imem_req`=0 throughout; release -> next fetch at `ir_pc`+1.
- Redirect to 8'h40 while in HOLD -> `ir_valid`=0 next cycle, `imem_addr`=8'h40, and the fetched instruction has `ir_pc`=8'h40.
- Memory with 3 wait cycles, redirect to 8'h80 during the wait -> `imem_addr` stays at the old address until ack, the returned data never appears in the IR, and the next request is at 8'h80; with the macro defined, `fetch_wait_cnt` increments by 3, plus 1 per wait cycle of the 8'h80 fetch.
- `PC_W`=8, start fetch at 8'hFF -> `ir_pc`=8'hFF, followed by a fetch at 8'h00.
- Assert `rst` in the same cycle as `imem_ack` and `redirect_en` -> next cycle `pc`=RESET_PC, `ir_valid`=0, `fetch_wait_cnt`=0.
